// File: rtl/async_fifo_pkg.sv
// Async FIFO shared helpers.
// Gray/binary conversion used by both pointer domains.
package async_fifo_pkg;

    // Working width of the helpers; callers zero-extend and truncate.
    localparam int GW = 32;

    function automatic logic [GW-1:0] bin2gray(
        input logic [GW-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // Zero-extended Gray input decodes identically at any width.
    function automatic logic [GW-1:0] gray2bin(
        input logic [GW-1:0] g
    );
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_fwft_skid2.sv
// Two-entry first-word-fall-through buffer.
// Head entry is always e0; push and pop may coincide.
module rd_skid2 #(
    parameter int DW = 8
) (
    input  logic          rclk,
    input  logic          rrst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic [1:0]    cnt
);

    logic [DW-1:0] e0;
    logic [DW-1:0] e1;

    assign dout  = e0;
    assign valid = (cnt != 2'd0);

    // In-order storage update; push into a full buffer never occurs.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= 2'd0;
        end else begin
            unique case (1'b1)
                push && !pop: begin
                    if (cnt == 2'd0) e0 <= din;
                    else             e1 <= din;
                    cnt <= cnt + 2'd1;
                end
                !push && pop: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                push && pop: begin
                    if (cnt == 2'd2) begin
                        e0 <= e1;
                        e1 <= din;
                    end else begin
                        e0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rptr_empty_fwft.sv
// Read-domain pointer, empty/level flags and FWFT front end.
// RAM is sync-read; fetched words land in a 2-entry stage.
module rptr_empty_fwft
    import async_fifo_pkg::*;
#(
    parameter int AW        = 4,
    parameter int DW        = 8,
    parameter int AE_THRESH = 2
) (
    input  logic          rclk,
    input  logic          rrst,
    input  logic [AW:0]   rq2_wptr,
    output logic [AW:0]   rptr,
    output logic [AW-1:0] raddr,
    output logic          rd_en,
    input  logic [DW-1:0] rdata_mem,
    output logic          rempty,
    output logic [AW:0]   rlevel,
    output logic          ralmost_empty,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready
);

    localparam int PW = AW + 1;
    localparam logic [AW:0] AE_T = PW'(AE_THRESH);

    logic [AW:0] rbin;
    logic [AW:0] rbin_next;
    logic [AW:0] rgray_next;
    logic [AW:0] wbin;
    logic [AW:0] lvl;
    logic        inflight;
    logic        pop;
    logic [1:0]  ob_cnt;
    logic [2:0]  occ;

    assign pop = dout_valid & dout_ready;

    // Stage occupancy once the in-flight word lands and the pop leaves.
    assign occ = {1'b0, ob_cnt}
               + {2'b00, inflight}
               - {2'b00, pop};

    assign rd_en = !rrst && !rempty && (occ < 3'd2);

    assign rbin_next  = rbin + {{AW{1'b0}}, rd_en};
    assign rgray_next = PW'(bin2gray(GW'(rbin_next)));
    assign wbin       = PW'(gray2bin(GW'(rq2_wptr)));
    assign lvl        = wbin - rbin_next;
    assign raddr      = rbin[AW-1:0];

    // Pointer, flag, level and fetch-pipeline registers.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            rlevel        <= '0;
            ralmost_empty <= 1'b1;
            inflight      <= 1'b0;
        end else begin
            rbin          <= rbin_next;
            rptr          <= rgray_next;
            rempty        <= (rgray_next == rq2_wptr);
            rlevel        <= lvl;
            ralmost_empty <= (lvl <= AE_T);
            inflight      <= rd_en;
        end
    end

    rd_skid2 #(
        .DW(DW)
    ) u_skid (
        .rclk  (rclk),
        .rrst  (rrst),
        .push  (inflight),
        .pop   (pop),
        .din   (rdata_mem),
        .dout  (dout),
        .valid (dout_valid),
        .cnt   (ob_cnt)
    );

endmodule
